// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the instruction-trace capture block: FSM encoding and
// the pointer-width helper.
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/riscv_trace_buffer_ram.sv
// Simple dual-port sample store: synchronous write, registered read giving a
// one-cycle read latency.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset so the popped data reads as zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/riscv_trace_buffer.sv
// Retired-instruction trace capture: circular (PC, instr) buffer with free-run,
// PC-trigger, stop and timeout termination, drained oldest-first once DONE.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_valid,
  input  logic [XLEN-1:0]        cap_pc,
  input  logic [31:0]            cap_instr,
  input  logic                   mode,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic [CNT_W-1:0]       post_trig,
  input  logic [CNT_W-1:0]       timeout,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   rd_en,
  output logic [XLEN-1:0]        rd_pc,
  output logic [31:0]            rd_instr,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic                   done,
  output logic                   halt_req
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = XLEN + 32;

  trace_state_e   state_q, state_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic           halt_q, halt_d;
  logic           rd_valid_q;

  logic           we;
  logic           pop;
  logic           active;
  logic           trig_hit;
  logic           tmo_hit;
  logic [DW-1:0]  rdata;

  assign active   = (state_q == CAPTURE) || (state_q == POST);
  assign trig_hit = (state_q == CAPTURE) && mode && cap_valid && (cap_pc == trig_pc);
  assign tmo_hit  = active && (timeout != '0) && (cyc_q == timeout - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cyc_d    = cyc_q;
    rem_d    = rem_q;
    halt_d   = halt_q;
    we       = 1'b0;
    pop      = 1'b0;

    if (arm) begin
      state_d  = CAPTURE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      cyc_d    = '0;
      halt_d   = 1'b0;
    end else begin
      case (state_q)
        CAPTURE, POST: begin
          cyc_d = cyc_q + CNT_W'(1);
          if (cap_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (count_q < CW'(DEPTH)) begin
              count_d = count_q + CW'(1);
            end else begin
              // Full: the write lands on the oldest entry, so drop it.
              rd_ptr_d = rd_ptr_q + PW'(1);
            end
          end
          if (trig_hit) begin
            if (post_trig == '0) begin
              state_d = DONE;
            end else begin
              state_d = POST;
              rem_d   = post_trig;
            end
          end
          if ((state_q == POST) && cap_valid) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = DONE;
            end
          end
          if (stop || tmo_hit) begin
            state_d = DONE;
          end
          if (tmo_hit) begin
            halt_d = 1'b1;
          end
        end
        DONE: begin
          if (rd_en && (count_q != '0)) begin
            pop      = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      rem_q      <= '0;
      halt_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      rem_q      <= rem_d;
      halt_q     <= halt_d;
      rd_valid_q <= pop;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ({cap_pc, cap_instr}),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign rd_pc    = rdata[DW-1:32];
  assign rd_instr = rdata[31:0];
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign state    = state_q;
  assign done     = (state_q == DONE);
  assign halt_req = halt_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer: expected pops are queued as stimulus is
// issued and a negedge monitor compares every rd_valid beat against the queue.
module tb_riscv_trace_buffer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic                   clk;
  logic                   reset;
  logic                   cap_valid;
  logic [XLEN-1:0]        cap_pc;
  logic [31:0]            cap_instr;
  logic                   mode;
  logic [XLEN-1:0]        trig_pc;
  logic [CNT_W-1:0]       post_trig;
  logic [CNT_W-1:0]       timeout;
  logic                   arm;
  logic                   stop;
  logic                   rd_en;
  logic [XLEN-1:0]        rd_pc;
  logic [31:0]            rd_instr;
  logic                   rd_valid;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]             state;
  logic                   done;
  logic                   halt_req;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } smp_t;

  smp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  riscv_trace_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_valid (cap_valid),
    .cap_pc    (cap_pc),
    .cap_instr (cap_instr),
    .mode      (mode),
    .trig_pc   (trig_pc),
    .post_trig (post_trig),
    .timeout   (timeout),
    .arm       (arm),
    .stop      (stop),
    .rd_en     (rd_en),
    .rd_pc     (rd_pc),
    .rd_instr  (rd_instr),
    .rd_valid  (rd_valid),
    .count     (count),
    .state     (state),
    .done      (done),
    .halt_req  (halt_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid beat must match the oldest queued sample.
  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rd_valid: got pc 0x%0h expected no pop", rd_pc);
      end else begin
        smp_t e;
        e = exp_q.pop_front();
        chk("rd_pc", 64'(rd_pc), 64'(e.pc));
        chk("rd_instr", 64'(rd_instr), 64'(e.instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    smp_t s;
    s.pc    = pc;
    s.instr = mk_instr(pc);
    exp_q.push_back(s);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic sample(input logic [31:0] pc);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = mk_instr(pc);
    tick();
    cap_valid = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
    tick();
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    cap_valid = 1'b0;
    cap_pc    = '0;
    cap_instr = '0;
    mode      = 1'b0;
    trig_pc   = '0;
    post_trig = '0;
    timeout   = '0;
    arm       = 1'b0;
    stop      = 1'b0;
    rd_en     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-capture
    arm_pulse();
    for (int i = 0; i < 3; i++) sample(32'h1000 + 32'(i * 4));
    chk("pre_reset_count", 64'(count), 64'd3);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_halt", 64'(halt_req), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_pc", 64'(rd_pc), 64'd0);

    // Free-run wrap
    mode = 1'b0;
    arm_pulse();
    chk("fr_state_capture", 64'(state), 64'd1);
    for (int i = 0; i < 20; i++) sample(32'(i * 4));
    chk("fr_count_full", 64'(count), 64'd16);
    stop_pulse();
    chk("fr_state_done", 64'(state), 64'd3);
    chk("fr_done", 64'(done), 64'd1);
    chk("fr_count_done", 64'(count), 64'd16);
    for (int i = 4; i < 20; i++) push(32'(i * 4));
    drain(17);

    // PC trigger with three post-trigger samples
    mode      = 1'b1;
    trig_pc   = 32'h40;
    post_trig = 16'd3;
    arm_pulse();
    for (int i = 0; i < 20; i++) begin
      sample(32'(i * 4));
      if (i == 16) chk("trig_state_post", 64'(state), 64'd2);
      if (i == 18) chk("trig_state_post_last", 64'(state), 64'd2);
    end
    chk("trig_state_done", 64'(state), 64'd3);
    chk("trig_count", 64'(count), 64'd16);
    sample(32'h50);
    chk("trig_no_write_in_done", 64'(count), 64'd16);
    for (int i = 4; i < 20; i++) push(32'(i * 4));
    drain(16);

    // Timeout with cap_valid held, including in the arm cycle
    mode      = 1'b0;
    timeout   = 16'd10;
    cap_valid = 1'b1;
    cap_pc    = 32'h999;
    cap_instr = mk_instr(32'h999);
    arm_pulse();
    for (int k = 0; k < 10; k++) begin
      cap_valid = 1'b1;
      cap_pc    = 32'h100 + 32'(k * 4);
      cap_instr = mk_instr(cap_pc);
      tick();
      if (k == 8) begin
        chk("tmo_state_before", 64'(state), 64'd1);
        chk("tmo_halt_before", 64'(halt_req), 64'd0);
      end
    end
    cap_valid = 1'b0;
    chk("tmo_done", 64'(done), 64'd1);
    chk("tmo_halt", 64'(halt_req), 64'd1);
    chk("tmo_count", 64'(count), 64'd10);
    for (int k = 0; k < 10; k++) push(32'h100 + 32'(k * 4));
    drain(10);
    chk("tmo_halt_sticky", 64'(halt_req), 64'd1);
    timeout = '0;

    // Re-arm during POST
    mode      = 1'b1;
    trig_pc   = 32'h8;
    post_trig = 16'd5;
    arm_pulse();
    chk("rearm_halt_cleared_first", 64'(halt_req), 64'd0);
    for (int i = 0; i < 4; i++) sample(32'(i * 4));
    chk("rearm_state_post", 64'(state), 64'd2);
    chk("rearm_count_post", 64'(count), 64'd4);
    cap_valid = 1'b1;
    cap_pc    = 32'h777;
    cap_instr = mk_instr(32'h777);
    arm_pulse();
    cap_valid = 1'b0;
    chk("rearm_count", 64'(count), 64'd0);
    chk("rearm_state", 64'(state), 64'd1);
    chk("rearm_halt", 64'(halt_req), 64'd0);
    sample(32'h200);
    stop_pulse();
    chk("rearm_count_one", 64'(count), 64'd1);
    push(32'h200);
    drain(2);

    // rd_en held during CAPTURE is ignored
    mode = 1'b0;
    arm_pulse();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(32'h300 + 32'(i * 4));
      chk("ign_rd_valid", 64'(rd_valid), 64'd0);
    end
    tick();
    chk("ign_rd_valid_idle", 64'(rd_valid), 64'd0);
    rd_en = 1'b0;
    chk("ign_count", 64'(count), 64'd3);
    stop_pulse();
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i * 4));
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
